// File: rtl/store_rmw_unit.sv
// Store narrowing unit for a word-wide, synchronous-read RAM without byte enables.
// Sub-word stores use an IDLE -> READ -> DONE read-modify-write sequence.
// Define STORE_BYTE_ENABLE_EN to add mem_be_o and make sub-word stores complete in a single cycle.
module store_rmw_unit #(
  parameter int MEM_AW = 12
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [1:0]        size_i,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
`ifdef STORE_BYTE_ENABLE_EN
  output logic [3:0]        mem_be_o,
`endif
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       ld_word_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              done_o
);

  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [MEM_AW+1:0]   addr_q;
  logic [15:0]         wdata_q;
  logic [1:0]          size_q;
  logic                latch_en;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^addr_i[31:MEM_AW+2];
  assign ld_word_o      = mem_rdata_i;

  function automatic logic is_word(input logic [1:0] sz);
    return (sz != SZ_HALF) && (sz != SZ_BYTE);
  endfunction

  function automatic logic misaligned(input logic [1:0] lo, input logic [1:0] sz);
    logic bad;
    bad = 1'b0;
    if (sz == SZ_HALF)
      bad = lo[0];
    else if (is_word(sz))
      bad = (lo != 2'b00);
    return bad;
  endfunction

  // Replace only the addressed lane(s) of the old word with the narrowed data
  function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [15:0] d,
                                             input logic [1:0] lo, input logic [1:0] sz);
    logic [31:0] r;
    r = old;
    if (sz == SZ_BYTE)
      r[{lo, 3'b000} +: 8] = d[7:0];
    else if (sz == SZ_HALF) begin
      if (lo[1])
        r[31:16] = d;
      else
        r[15:0] = d;
    end
    return r;
  endfunction

`ifdef STORE_BYTE_ENABLE_EN
  function automatic logic [3:0] lane_mask(input logic [1:0] lo, input logic [1:0] sz);
    logic [3:0] m;
    m = 4'b1111;
    if (sz == SZ_BYTE)
      m = 4'b0001 << lo;
    else if (sz == SZ_HALF)
      m = lo[1] ? 4'b1100 : 4'b0011;
    return m;
  endfunction

  function automatic logic [31:0] replicate(input logic [15:0] d, input logic [1:0] sz);
    return (sz == SZ_BYTE) ? {4{d[7:0]}} : {2{d}};
  endfunction
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        addr_q  <= addr_i[MEM_AW+1:0];
        wdata_q <= wdata_i[15:0];
        size_q  <= size_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    latch_en    = 1'b0;
    mem_addr_o  = addr_i[MEM_AW+1:2];
    mem_we_o    = 1'b0;
    mem_wdata_o = wdata_i;
`ifdef STORE_BYTE_ENABLE_EN
    mem_be_o    = 4'b1111;
`endif
    stall_o     = 1'b0;
    misalign_o  = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        misalign_o = req_i & misaligned(addr_i[1:0], size_i);
        if (req_i && we_i && !misalign_o) begin
          if (is_word(size_i)) begin
            mem_we_o = 1'b1;
            done_o   = 1'b1;
          end else begin
`ifdef STORE_BYTE_ENABLE_EN
            mem_we_o    = 1'b1;
            done_o      = 1'b1;
            mem_be_o    = lane_mask(addr_i[1:0], size_i);
            mem_wdata_o = replicate(wdata_i[15:0], size_i);
`else
            // This cycle presents the address for the RAM read half of the RMW
            latch_en = 1'b1;
            stall_o  = 1'b1;
            state_d  = READ;
`endif
          end
        end
      end
      READ: begin
        mem_addr_o  = addr_q[MEM_AW+1:2];
        mem_wdata_o = merge_lane(mem_rdata_i, wdata_q, addr_q[1:0], size_q);
        mem_we_o    = 1'b1;
        stall_o     = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        mem_addr_o = addr_q[MEM_AW+1:2];
        done_o     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reset cycle must never write the RAM or signal the pipeline
    if (reset_i) begin
      mem_we_o   = 1'b0;
      stall_o    = 1'b0;
      misalign_o = 1'b0;
      done_o     = 1'b0;
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Scoreboard bench for store_rmw_unit: directed stores/loads against a word RAM model.
module tb_store_rmw_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata, ld_word;
  logic        stall, misalign, done;
  logic [3:0]  mem_be;
  logic [31:0] mem [0:4095];

  int n_cmp = 0;
  int n_err = 0;

`ifdef STORE_BYTE_ENABLE_EN
  localparam int SUBCYC = 1;
  localparam int SUBSTALL = 0;
`else
  localparam int SUBCYC = 3;
  localparam int SUBSTALL = 2;
  assign mem_be = 4'b1111;
`endif

  store_rmw_unit #(.MEM_AW(12)) dut (
    .clk_i(clk), .reset_i(reset), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .size_i(size), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata),
`ifdef STORE_BYTE_ENABLE_EN
    .mem_be_o(mem_be),
`endif
    .mem_rdata_i(mem_rdata), .ld_word_o(ld_word), .stall_o(stall),
    .misalign_o(misalign), .done_o(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= mem[mem_addr];
  end

  typedef enum {EV_WR, EV_DN} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ev_t;
  ev_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    ev_t e;
    e.kind = EV_WR; e.addr = a; e.data = d; e.be = be;
    exp_q.push_back(e);
  endtask

  task automatic push_dn();
    ev_t e;
    e.kind = EV_DN; e.addr = '0; e.data = '0; e.be = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_store(input logic [11:0] a, input logic [31:0] merged,
                            input logic [31:0] repl, input logic [3:0] be);
`ifdef STORE_BYTE_ENABLE_EN
    push_wr(a, repl, be);
`else
    push_wr(a, merged, 4'b1111);
`endif
    push_dn();
  endtask

  // Monitor: every write strobe and done pulse must match the next expected event
  always @(negedge clk) begin
    ev_t e;
    if (mem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != EV_WR) begin
          n_err++;
          $display("FAIL write_order: got write, required done pulse");
        end else begin
          chk("wr_addr", {20'b0, mem_addr}, {20'b0, e.addr});
          chk("wr_data", mem_wdata, e.data);
          chk("wr_be", {28'b0, mem_be}, {28'b0, e.be});
        end
      end
    end
    if (done) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got done pulse, required none");
      end else begin
        e = exp_q.pop_front();
        if (e.kind != EV_DN) begin
          n_err++;
          $display("FAIL done_order: got done pulse, required write");
        end
      end
    end
  end

  // Holds the instruction in MEM until stall drops, as the pipeline would
  task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, output int cyc, output int stl,
                       output int dn, output int mis);
    bit held;
    req = 1'b1; we = w; addr = a; wdata = d; size = sz;
    cyc = 0; stl = 0; dn = 0; mis = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cyc++;
      held = stall;
      if (stall) stl++;
      if (done) dn++;
      if (misalign) mis++;
      @(posedge clk); #1;
      if (!held) return;
    end
    n_cmp++; n_err++;
    $display("FAIL op_timeout: got stall still high after 8 cycles, required release");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, s, d, m, c2, s2, d2, m2;
    reset = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h13; wdata = '0; size = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_misalign", {31'b0, misalign}, 0);
    chk("rst_done", {31'b0, done}, 0);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;

    // sw then sb into the same word
    push_wr(12'h3, 32'hAABBCCDD, 4'hF); push_dn();
    do_op(1, 32'hC, 32'hAABBCCDD, 2'b00, c, s, d, m);
    chk("sw_cycles", c, 1); chk("sw_stall", s, 0); chk("sw_done", d, 1);
    push_store(12'h3, 32'hAABB11DD, 32'h11111111, 4'b0010);
    do_op(1, 32'hD, 32'h11, 2'b10, c, s, d, m);
    chk("sb_cycles", c, SUBCYC); chk("sb_stall", s, SUBSTALL); chk("sb_done", d, 1);
    chk("sb_mem3", mem[3], 32'hAABB11DD);

    // sh onto upper half, then load back
    push_wr(12'h4, 32'h01234567, 4'hF); push_dn();
    do_op(1, 32'h10, 32'h01234567, 2'b00, c, s, d, m);
    push_store(12'h4, 32'hBEEF4567, 32'hBEEFBEEF, 4'b1100);
    do_op(1, 32'h12, 32'h0000BEEF, 2'b01, c, s, d, m);
    chk("sh_stall", s, SUBSTALL);
    chk("sh_mem4", mem[4], 32'hBEEF4567);
    do_op(0, 32'h10, 32'h0, 2'b00, c, s, d, m);
    chk("lw_stall", s, 0); chk("lw_done", d, 0);
    req = 1'b0;
    @(negedge clk);
    chk("lw_ld_word", ld_word, 32'hBEEF4567);
    @(posedge clk); #1;

    // misaligned half and word
    push_wr(12'h1, 32'hCAFEF00D, 4'hF); push_dn();
    do_op(1, 32'h4, 32'hCAFEF00D, 2'b00, c, s, d, m);
    do_op(1, 32'h13, 32'h1234, 2'b01, c, s, d, m);
    chk("mis_sh_flag", m, 1); chk("mis_sh_stall", s, 0); chk("mis_sh_done", d, 0);
    do_op(1, 32'h6, 32'h12345678, 2'b00, c, s, d, m);
    chk("mis_sw_flag", m, 1); chk("mis_sw_stall", s, 0);
    req = 1'b0;
    @(posedge clk); #1;
    chk("mis_mem4", mem[4], 32'hBEEF4567);
    chk("mis_mem1", mem[1], 32'hCAFEF00D);

    // back-to-back byte stores
    push_wr(12'h8, 32'h0, 4'hF); push_dn();
    do_op(1, 32'h20, 32'h0, 2'b00, c, s, d, m);
    push_store(12'h8, 32'h00000001, 32'h01010101, 4'b0001);
    push_store(12'h8, 32'h00000201, 32'h02020202, 4'b0010);
    do_op(1, 32'h20, 32'h01, 2'b10, c, s, d, m);
    do_op(1, 32'h21, 32'h02, 2'b10, c2, s2, d2, m2);
    chk("b2b_cycles", c + c2, 2 * SUBCYC);
    chk("b2b_dones", d + d2, 2);
    chk("b2b_mem8", mem[8], 32'h00000201);

`ifndef STORE_BYTE_ENABLE_EN
    // reset while READ is in flight
    push_wr(12'h9, 32'h55667788, 4'hF); push_dn();
    do_op(1, 32'h24, 32'h55667788, 2'b00, c, s, d, m);
    req = 1'b1; we = 1'b1; addr = 32'h24; wdata = 32'h99; size = 2'b10;
    @(negedge clk);
    chk("rr_accept_stall", {31'b0, stall}, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rr_mem_we", {31'b0, mem_we}, 0);
    chk("rr_stall", {31'b0, stall}, 0);
    @(posedge clk); #1;
    reset = 1'b0; req = 1'b0;
    @(negedge clk);
    chk("rr_after_stall", {31'b0, stall}, 0);
    chk("rr_after_done", {31'b0, done}, 0);
    chk("rr_mem9", mem[9], 32'h55667788);
    @(posedge clk); #1;
    push_store(12'h9, 32'h5566AB88, 32'hABABABAB, 4'b0010);
    do_op(1, 32'h25, 32'hAB, 2'b10, c, s, d, m);
    chk("rr_next_cycles", c, 3);
    chk("rr_next_mem9", mem[9], 32'h5566AB88);
`endif

    // byte into lane 2
    push_store(12'h3, 32'hAA5A11DD, 32'h5A5A5A5A, 4'b0100);
    do_op(1, 32'hE, 32'h5A, 2'b10, c, s, d, m);
    chk("sb_e_cycles", c, SUBCYC); chk("sb_e_stall", s, SUBSTALL); chk("sb_e_done", d, 1);
    chk("sb_e_mem3", mem[3], 32'hAA5A11DD);

    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- MEM-stage store narrowing unit, the inverse of immediate/load widening: it takes a 32-bit register value and narrows it to word, halfword or byte.
- It merges the narrowed value into a word-wide, synchronous-read data memory that has no byte enables, using a read-modify-write sequence.
- It stalls the pipeline while a sub-word store is in flight and flags misaligned accesses.
- Loads pass through as raw words; the downstream load extender handles them.

Parameters:
- MEM_AW, 12, word-address width of the data memory (byte address bits [MEM_AW+1:2]).

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- req  input  1  MEM stage holds a valid memory instruction
- we  input  1  1 = store, 0 = load
- addr  input  32  byte address
- wdata  input  32  store data from the register file
- size  input  2  00 = word, 01 = half, 10 = byte, 11 = reserved (treated as word)
- mem_addr  output  MEM_AW  word address to the RAM
- mem_we  output  1  RAM write strobe
- mem_wdata  output  32  RAM write word
- mem_rdata  input  32  RAM read word, valid one cycle after mem_addr
- ld_word  output  32  raw loaded word (equals mem_rdata)
- stall  output  1  hold the IF/ID/EX/MEM stages
- misalign  output  1  address exception for the current request
- done  output  1  one-cycle pulse when a store commits

Behaviour:
- Reset values: state = IDLE; mem_we, stall, misalign and done = 0; latched address, data and size registers = 0. Reset mid-operation aborts the sequence, and no mem_we is asserted in the reset cycle.
- Misaligned, combinational:
  - half with addr[0] = 1, or word with addr[1:0] != 0;
  - misalign = req & condition, in IDLE only;
  - no write, no stall, state unchanged.
- Lane select (little-endian):
  - byte k = addr[1:0] occupies bits [8k+7:8k];
  - half h = addr[1] occupies bits [16h+15:16h];
  - narrowed source is wdata[7:0] or wdata[15:0].
- States: IDLE, READ, DONE.
- IDLE:
  - mem_addr = addr[MEM_AW+1:2].
  - Aligned word store: mem_we = 1, mem_wdata = wdata, done = 1, stall = 0; stays in IDLE.
  - Load: mem_we = 0, stall = 0, no state change.
  - Aligned sub-word store: latch addr, wdata and size; mem_we = 0 (this cycle is the RAM read); stall = 1; next state READ.
- READ:
  - mem_addr = latched word address.
  - mem_wdata = mem_rdata with only the selected lane(s) replaced by the narrowed data.
  - mem_we = 1, stall = 1, inputs ignored; next state DONE.
- DONE:
  - stall = 0, done = 1, mem_we = 0; the instruction leaves MEM.
  - req is not accepted this cycle; next state IDLE.
- Latency: word store 1 cycle, no stall. Sub-word store 3 cycles, with stall high for 2 cycles (IDLE-accept and READ).
- Back-to-back sub-word stores: the second one is accepted in the IDLE cycle after DONE, so there is no lost or duplicated write.
- ld_word = mem_rdata at all times.

Optional Feature:
- STORE_BYTE_ENABLE_EN defined:
  - adds output mem_be[3:0], and the RAM honours it;
  - sub-word stores complete in IDLE in one cycle: mem_we = 1, mem_be = lane mask, mem_wdata = narrowed data replicated across lanes, done = 1, stall never asserted;
  - READ and DONE are unreachable and may be omitted.
- Not defined: no mem_be port; the read-modify-write sequence applies as above.

Test Plan:
- sw: word 0x3 = 0xAABBCCDD, then sb addr 0xD, wdata 0x11 -> stall high 2 cycles, mem_we in READ, word 0x3 = 0xAABB11DD, done pulses in DONE.
- sh addr 0x12, wdata 0x0000BEEF onto word 0x4 = 0x01234567 -> word 0x4 = 0xBEEF4567; then lw addr 0x10 -> ld_word = 0xBEEF4567 the next cycle.
- Misalign: sh addr 0x13 -> misalign = 1, no mem_we, stall = 0, memory unchanged. Same for sw addr 0x6.
- Back-to-back: sb 0x20 = 0x01, then sb 0x21 = 0x02, onto word 0x8 = 0x0 -> word 0x8 = 0x00000201, 6 total cycles, two done pulses.
- Reset asserted during READ -> no write, state IDLE, stall = 0 next cycle, target word unchanged.
- With STORE_BYTE_ENABLE_EN: sb addr 0xE, wdata 0x5A -> mem_be = 0100, mem_wdata = 0x5A5A5A5A, stall never high, done the same cycle.
